// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative RV32M/RV64M multiply/divide sequencer for the EX stage.
// Detects M-extension R-type ops, stalls the front of the pipe while it works, and
// presents a one-cycle-valid Result for the EX/MEM register.
// Build option: define MDU_FAST_MUL_EN to replace the shift-add multiply with a
// single-cycle signed (XLEN+1)x(XLEN+1) product (divide is unaffected).
module mdu_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_in,
    input  logic            flush,
    input  logic [1:0]      ALUOp,
    input  logic [6:0]      Funct7,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    output logic            MExt,
    output logic            Stall,
    output logic            ResultValid,
    output logic [XLEN-1:0] Result
);
    // state  | meaning
    // IDLE   | waiting for an M-op; issue cycle stalls combinationally
    // BUSY   | one multiply/divide step per cycle, counter walks down to 0
    // DONE   | sign fix-up applied, Result valid for one cycle, pipe released

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic [XLEN-1:0]     a_q, a_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic                neg_q, neg_d;
    logic                spec_q, spec_d;
    logic [XLEN-1:0]     spec_val_q, spec_val_d;
    logic [XLEN-1:0]     result_q, result_d;
`ifdef MDU_FAST_MUL_EN
    logic                a_ext_q, a_ext_d;
    logic                b_ext_q, b_ext_d;
    logic signed [2*XLEN+1:0] fast_prod;
`else
    logic [XLEN:0]       mul_sum;
`endif

    logic                start;
    logic                is_div, a_signed, b_signed, sign_a, sign_b;
    logic                div_zero, div_ovf;
    logic [XLEN-1:0]     abs_a, abs_b;
    logic [2*XLEN-1:0]   mul_next;
    logic [XLEN:0]       div_sh, div_trial;
    logic [XLEN-1:0]     div_rem;
    logic                div_bit;
    logic [2*XLEN-1:0]   full_mag;
    logic [XLEN-1:0]     div_pick, div_val, fix;

    // Decode and operand conditioning for the instruction currently in ID/EX
    always_comb begin
        MExt     = (ALUOp == 2'b10) && (Funct7 == 7'b0000001);
        start    = valid_in && MExt && !flush;
        is_div   = Funct3[2];
        // MUL/MULH/MULHSU treat rs1 as signed; only MULH treats rs2 as signed
        // (MUL's low half is sign-agnostic, so it shares the MULH path).
        a_signed = is_div ? ~Funct3[0] : (Funct3[1:0] != 2'b11);
        b_signed = is_div ? ~Funct3[0] : ~Funct3[1];
        sign_a   = a_signed & SrcA[XLEN-1];
        sign_b   = b_signed & SrcB[XLEN-1];
        abs_a    = sign_a ? -SrcA : SrcA;
        abs_b    = sign_b ? -SrcB : SrcB;
        div_zero = is_div && (SrcB == '0);
        div_ovf  = is_div && !Funct3[0] && (SrcA == MOST_NEG) && (SrcB == '1);
    end

    // One multiply step and one restoring-divide step on the shared accumulator
    always_comb begin
`ifdef MDU_FAST_MUL_EN
        fast_prod = $signed({a_ext_q, a_q}) * $signed({b_ext_q, b_q});
        mul_next  = (2*XLEN)'(fast_prod);
`else
        // Multiplier sits in the low half and shifts out one bit per step.
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
`endif
        // Remainder in the high half, dividend/quotient bits shift through the low half.
        div_sh    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_trial = div_sh - {1'b0, b_q};
        if (!div_trial[XLEN]) begin
            div_rem = div_trial[XLEN-1:0];
            div_bit = 1'b1;
        end else begin
            div_rem = div_sh[XLEN-1:0];
            div_bit = 1'b0;
        end
    end

    // Final sign fix-up and special-case override, consumed in DONE
    always_comb begin
        full_mag = neg_q ? -acc_q : acc_q;
        div_pick = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
        div_val  = neg_q ? -div_pick : div_pick;
        if (op_q[2]) begin
            fix = spec_q ? spec_val_q : div_val;
        end else if (op_q[1:0] == 2'b00) begin
            fix = full_mag[XLEN-1:0];
        end else begin
            fix = full_mag[2*XLEN-1:XLEN];
        end
    end

    // Next-state and datapath register updates
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        neg_d      = neg_q;
        spec_d     = spec_q;
        spec_val_d = spec_val_q;
        result_d   = result_q;
`ifdef MDU_FAST_MUL_EN
        a_ext_d    = a_ext_q;
        b_ext_d    = b_ext_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_BUSY;
                    op_d       = Funct3;
                    a_d        = abs_a;
                    b_d        = abs_b;
                    // Quotient and products take sA^sB; remainders follow the dividend.
                    neg_d      = (is_div && Funct3[1]) ? sign_a : (sign_a ^ sign_b);
                    spec_d     = div_zero || div_ovf;
                    if (div_zero) begin
                        spec_val_d = Funct3[1] ? SrcA : '1;
                    end else begin
                        spec_val_d = Funct3[1] ? '0 : SrcA;
                    end
                    acc_d      = {{XLEN{1'b0}}, (is_div ? abs_a : abs_b)};
                    cnt_d      = CW'(XLEN - 1);
`ifdef MDU_FAST_MUL_EN
                    if (!is_div) begin
                        // Signed product handles the signs itself; no fix-up needed.
                        a_d     = SrcA;
                        b_d     = SrcB;
                        a_ext_d = sign_a;
                        b_ext_d = sign_b;
                        neg_d   = 1'b0;
                        cnt_d   = '0;
                    end
`endif
                end
            end
            S_BUSY: begin
                acc_d = op_q[2] ? {div_rem, acc_q[XLEN-2:0], div_bit} : mul_next;
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                // The stalled instruction is still in ID/EX, so valid_in is not looked at.
                state_d = S_IDLE;
                if (!flush) begin
                    result_d = fix;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            neg_q      <= 1'b0;
            spec_q     <= 1'b0;
            spec_val_q <= '0;
            result_q   <= '0;
`ifdef MDU_FAST_MUL_EN
            a_ext_q    <= 1'b0;
            b_ext_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            neg_q      <= neg_d;
            spec_q     <= spec_d;
            spec_val_q <= spec_val_d;
            result_q   <= result_d;
`ifdef MDU_FAST_MUL_EN
            a_ext_q    <= a_ext_d;
            b_ext_q    <= b_ext_d;
`endif
        end
    end

    // Pipeline-facing outputs; a flush in DONE squashes the result presentation
    always_comb begin
        Stall       = !reset && (((state_q == S_IDLE) && start) || (state_q == S_BUSY));
        ResultValid = !reset && (state_q == S_DONE) && !flush;
        Result      = ResultValid ? fix : result_q;
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
`timescale 1ns/1ps
module tb_mdu_sequencer;
    localparam int XLEN = 32;
`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 32;
`endif
    localparam int DIV_LAT = 32;

    logic            clk = 1'b0;
    logic            reset, valid_in, flush;
    logic [1:0]      ALUOp;
    logic [6:0]      Funct7;
    logic [2:0]      Funct3;
    logic [XLEN-1:0] SrcA, SrcB;
    logic            MExt, Stall, ResultValid;
    logic [XLEN-1:0] Result;

    int tests = 0;
    int fails = 0;

    mdu_sequencer #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .flush(flush),
        .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3), .SrcA(SrcA), .SrcB(SrcB),
        .MExt(MExt), .Stall(Stall), .ResultValid(ResultValid), .Result(Result)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    // Architectural result from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, ua, ub, r;
        logic [63:0] w;
        bit ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'h0, a});
        ub  = longint'({32'h0, b});
        ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
        case (f3)
            3'b000: r = sa * sb;
            3'b001: r = (sa * sb) >> 32;
            3'b010: r = (sa * ub) >> 32;
            3'b011: r = (ua * ub) >> 32;
            3'b100: r = (b == 0) ? -1 : (ovf ? sa : sa / sb);
            3'b101: r = (b == 0) ? -1 : ua / ub;
            3'b110: r = (b == 0) ? sa : (ovf ? 0 : sa % sb);
            default: r = (b == 0) ? ua : ua % ub;
        endcase
        w = r;
        return w[31:0];
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 9))
            0: return 32'h00000000;
            1: return 32'h00000001;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            5: return 32'(($urandom_range(0, 20)));
            default: return $urandom();
        endcase
    endfunction

    task automatic idle_inputs();
        valid_in = 1'b0; flush = 1'b0; ALUOp = 2'b00; Funct7 = 7'b0;
        Funct3 = 3'b0; SrcA = '0; SrcB = '0;
    endtask

    // Issue one M-op at the current cycle T, follow it to DONE, and return just after
    // the edge that ends DONE with valid_in dropped.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
        int lat, seen;
        logic [31:0] exp;
        bit got, bad_busy;
        lat = f3[2] ? DIV_LAT : MUL_LAT;
        exp = ref_model(f3, a, b);
        valid_in = 1'b1; flush = 1'b0; ALUOp = 2'b10; Funct7 = 7'b0000001;
        Funct3 = f3; SrcA = a; SrcB = b;
        @(negedge clk);
        tests++;
        if (Stall !== 1'b1 || ResultValid !== 1'b0 || MExt !== 1'b1) begin
            fails++;
            $display("FAIL %s issue: Stall=%b ResultValid=%b MExt=%b, required 1 0 1",
                     tag, Stall, ResultValid, MExt);
        end
        got = 0; bad_busy = 0; seen = 0;
        for (int k = 1; k <= lat + 4 && !got; k++) begin
            @(negedge clk);
            if (ResultValid === 1'b1) begin
                got = 1;
                seen = k;
                tests++;
                if (Result !== exp) begin
                    fails++;
                    $display("FAIL %s result: f3=%0d a=%h b=%h got %h, expected %h",
                             tag, f3, a, b, Result, exp);
                end
                tests++;
                if (Stall !== 1'b0) begin
                    fails++;
                    $display("FAIL %s done_stall: Stall=%b, required 0", tag, Stall);
                end
            end else if (Stall !== 1'b1) begin
                bad_busy = 1;
            end
        end
        tests++;
        if (!got || seen != lat + 1) begin
            fails++;
            $display("FAIL %s latency: ResultValid at T+%0d (0=never), required T+%0d",
                     tag, seen, lat + 1);
        end
        tests++;
        if (bad_busy) begin
            fails++;
            $display("FAIL %s busy_stall: Stall dropped before DONE, required 1", tag);
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    // Confirms the sequencer stays idle for n cycles with nothing issued.
    task automatic expect_quiet(input int n, input string tag);
        bit bad;
        bad = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (ResultValid !== 1'b0 || Stall !== 1'b0) bad = 1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL %s quiet: saw ResultValid or Stall high, required both 0", tag);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        valid_in = 1'b1; ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = 3'b100;
        SrcA = 32'd9; SrcB = 32'd3;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        tests++;
        if (Stall !== 1'b0 || ResultValid !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold: Stall=%b ResultValid=%b, required 0 0", Stall, ResultValid);
        end
        tests++;
        if (MExt !== 1'b1) begin
            fails++;
            $display("FAIL reset_mext: MExt=%b, required 1", MExt);
        end
        @(posedge clk); #1;
        idle_inputs();
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (Stall !== 1'b0 || ResultValid !== 1'b0 || Result !== 32'h0 || MExt !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: Stall=%b RV=%b Result=%h MExt=%b, required 0 0 0 0",
                     Stall, ResultValid, Result, MExt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        run_op(3'b000, 32'd7, 32'hFFFFFFFD, "mul_7x-3");
        expect_quiet(2, "mul_7x-3");
        run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhu_max");
        run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulh_-1");
        run_op(3'b010, 32'hFFFFFFFF, 32'd2, "mulhsu");
        expect_quiet(2, "mul_group");
    endtask

    task automatic test_div();
        run_op(3'b100, 32'hFFFFFFF9, 32'd2, "div_-7/2");
        run_op(3'b110, 32'hFFFFFFF9, 32'd2, "rem_-7/2");
        run_op(3'b101, 32'd100, 32'd7, "divu_100/7");
        run_op(3'b111, 32'd100, 32'd7, "remu_100/7");
        expect_quiet(2, "div_group");
    endtask

    task automatic test_div_special();
        run_op(3'b100, 32'd5, 32'd0, "div_by0");
        run_op(3'b111, 32'd5, 32'd0, "remu_by0");
        run_op(3'b110, 32'hFFFFFFFB, 32'd0, "rem_neg_by0");
        run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
        run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, "rem_ovf");
        expect_quiet(2, "special_group");
    endtask

    task automatic test_non_m();
        bit bad;
        bad = 0;
        valid_in = 1'b1; ALUOp = 2'b10; Funct7 = 7'b0100000; Funct3 = 3'b000;
        SrcA = 32'd3; SrcB = 32'd4;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (Stall !== 1'b0 || MExt !== 1'b0 || ResultValid !== 1'b0) bad = 1;
            @(posedge clk); #1;
        end
        ALUOp = 2'b00; Funct7 = 7'b0000001;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (Stall !== 1'b0 || MExt !== 1'b0 || ResultValid !== 1'b0) bad = 1;
            @(posedge clk); #1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL non_m: Stall/MExt/ResultValid went high for a non-M op, required 0");
        end
        idle_inputs();
        run_op(3'b101, 32'd81, 32'd9, "after_non_m");
    endtask

    task automatic test_flush();
        valid_in = 1'b1; ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = 3'b100;
        SrcA = 32'd1000; SrcB = 32'd7;
        @(negedge clk);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; valid_in = 1'b0;
        @(negedge clk);
        tests++;
        if (Stall !== 1'b0 || ResultValid !== 1'b0) begin
            fails++;
            $display("FAIL flush_idle: Stall=%b ResultValid=%b at T+11, required 0 0",
                     Stall, ResultValid);
        end
        @(posedge clk); #1;
        expect_quiet(40, "flush_busy");
        valid_in = 1'b1; flush = 1'b1; ALUOp = 2'b10; Funct7 = 7'b0000001;
        Funct3 = 3'b000; SrcA = 32'd5; SrcB = 32'd6;
        @(negedge clk);
        tests++;
        if (Stall !== 1'b0) begin
            fails++;
            $display("FAIL flush_start: Stall=%b with flush and start together, required 0", Stall);
        end
        @(posedge clk); #1;
        idle_inputs();
        expect_quiet(40, "flush_start");
        run_op(3'b000, 32'd5, 32'd6, "after_flush");
    endtask

    task automatic test_back_to_back();
        run_op(3'b000, 32'd7, 32'hFFFFFFFD, "pre_reset_mul");
        valid_in = 1'b1; ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = 3'b100;
        SrcA = 32'd12345; SrcB = 32'd17;
        @(negedge clk);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        tests++;
        if (Stall !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_stall: Stall=%b while reset high, required 0", Stall);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (Stall !== 1'b0 || ResultValid !== 1'b0 || Result !== 32'h0) begin
            fails++;
            $display("FAIL reset_mid: Stall=%b RV=%b Result=%h, required 0 0 0",
                     Stall, ResultValid, Result);
        end
        @(posedge clk); #1;
        expect_quiet(40, "reset_mid");
        run_op(3'b000, 32'd1234, 32'd5678, "b2b_first");
        run_op(3'b000, 32'hFFFFFF00, 32'd3, "b2b_second");
        expect_quiet(3, "b2b");
    endtask

    task automatic test_random();
        logic [2:0] f3;
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            run_op(f3, pick(), pick(), "random");
            if ($urandom_range(0, 2) == 0) expect_quiet(1, "random_gap");
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_mul();
        test_div();
        test_div_special();
        test_non_m();
        test_flush();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
